// File: rtl/disp_pkg.sv
// Shared types and constants for the display operand-entry path.
package disp_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        SHOW  = 2'd1,
        OVF   = 2'd2
    } disp_state_t;

    localparam logic signed [7:0] SAT_MAX = 8'sd127;
    localparam logic signed [7:0] SAT_MIN = -8'sd128;

    localparam int KEY_CLEAR = 0;
    localparam int KEY_LOAD  = 1;
    localparam int KEY_ADD   = 2;

endpackage

// File: rtl/disp_input_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The level flips one edge after the count is reached, so the pulse lands
    // in the cycle after that edge and the top updates one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            pressed <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level   <= sync_q2;
                cnt     <= '0;
                pressed <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_input_ctrl.sv
// Operand entry/hold stage feeding disp_decimal: debounced keys, saturating add, overflow blink.
module disp_input_ctrl
    import disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       key_load_n,
    input  logic       key_add_n,
    input  logic       key_clear_n,
    output logic [7:0] x,
    output logic       enable,
    output logic       ovf
);

    localparam int BLINK_W = $clog2(BLINK_CYCLES) + 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [2:0] press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk(clk), .rst_n(rst_n), .key_n(key_clear_n), .pressed(press[KEY_CLEAR])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
        .clk(clk), .rst_n(rst_n), .key_n(key_load_n), .pressed(press[KEY_LOAD])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_add (
        .clk(clk), .rst_n(rst_n), .key_n(key_add_n), .pressed(press[KEY_ADD])
    );

    disp_state_t        state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic signed [8:0]  sum;

    assign sum = $signed({x_q[7], x_q}) + $signed({sw[7], sw});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            x_q         <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // x is 0 in BLANK, so the same sum covers the add-from-blank case.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;

        if (state_q == OVF) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_on_d  = blink_on_q;
            end
        end

        if (press[KEY_CLEAR]) begin
            state_d = BLANK;
            x_d     = '0;
        end else if (press[KEY_LOAD]) begin
            state_d = SHOW;
            x_d     = sw;
        end else if (press[KEY_ADD]) begin
            if (sum > 9'sd127) begin
                state_d     = OVF;
                x_d         = SAT_MAX;
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (sum < -9'sd128) begin
                state_d     = OVF;
                x_d         = SAT_MIN;
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else begin
                state_d = SHOW;
                x_d     = sum[7:0];
            end
        end
    end

    assign x      = x_q;
    assign enable = (state_q == SHOW) || ((state_q == OVF) && blink_on_q);
    assign ovf    = (state_q == OVF);

endmodule

// File: tb/tb_disp_input_ctrl.sv
// Scoreboard bench for disp_input_ctrl with short debounce and blink periods.
module tb_disp_input_ctrl;
    import disp_pkg::*;

    localparam int DB = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       key_load_n = 1'b1;
    logic       key_add_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [7:0] x;
    logic       enable;
    logic       ovf;

    disp_input_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .key_load_n(key_load_n), .key_add_n(key_add_n), .key_clear_n(key_clear_n),
        .x(x), .enable(enable), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [9:0]  want;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] cur_x = 8'h00;
    logic       cur_en = 1'b0;
    logic       cur_ovf = 1'b0;

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: x/en/ovf got %h/%b/%b want %h/%b/%b", nm,
                     act[9:2], act[1], act[0], want[9:2], want[1], want[0]);
        end
    endtask

    function automatic void expect_at(input int at, input logic [7:0] ex, input logic en,
                                      input logic ov, input string nm);
        exp_t e;
        e.at = at;
        e.want = {ex, en, ov};
        e.nm = nm;
        sb.push_back(e);
    endfunction

    function automatic void blink_expect(input int first, input int len, input logic [7:0] ex,
                                         input string nm);
        for (int i = 0; i < len; i++)
            expect_at(first + i, ex, ((i / BL) % 2) == 0, 1'b1, $sformatf("%s_%0d", nm, i));
    endfunction

    // Monitor: compare every expectation due after the current edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].nm, {x, enable, ovf}, sb[i].want);
                sb.delete(i);
            end
        end
    end

    task automatic set_key(input int k, input logic v);
        case (k)
            KEY_CLEAR: key_clear_n = v;
            KEY_LOAD:  key_load_n = v;
            default:   key_add_n = v;
        endcase
    endtask

    // Raw key first sampled at edge n; the result is due at edge n+DB+3.
    task automatic press(input int k, input logic [7:0] swv, input logic [7:0] nx,
                         input logic nen, input logic novf, input bit pre, input string nm);
        int n;
        sw = swv;
        n = cyc + 1;
        if (pre) expect_at(n + DB + 2, cur_x, cur_en, cur_ovf, {nm, "_early"});
        expect_at(n + DB + 3, nx, nen, novf, nm);
        set_key(k, 1'b0);
        repeat (6) @(negedge clk);
        set_key(k, 1'b1);
        repeat (12) @(negedge clk);
        cur_x = nx;
        cur_en = nen;
        cur_ovf = novf;
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clk);
        check("reset_state", {x, enable, ovf}, 10'h000);
        rst_n = 1'b1;
        expect_at(cyc + 5, 8'h00, 1'b0, 1'b0, "idle_blank");
        repeat (10) @(negedge clk);

        // load latency and hold
        sw = 8'hF3;
        n = cyc + 1;
        expect_at(n + 6, 8'h00, 1'b0, 1'b0, "load_early");
        expect_at(n + 7, 8'hF3, 1'b1, 1'b0, "load_latency");
        expect_at(n + 20, 8'hF3, 1'b1, 1'b0, "load_held");
        expect_at(n + 33, 8'hF3, 1'b1, 1'b0, "load_sw_change_ignored");
        key_load_n = 1'b0;
        repeat (10) @(negedge clk);
        sw = 8'h05;
        repeat (10) @(negedge clk);
        key_load_n = 1'b1;
        repeat (16) @(negedge clk);
        cur_x = 8'hF3; cur_en = 1'b1; cur_ovf = 1'b0;

        // bounce rejection
        press(KEY_LOAD, 8'h0A, 8'h0A, 1'b1, 1'b0, 1'b1, "load_10");
        sw = 8'h05;
        n = cyc + 1;
        expect_at(n + 8, 8'h0A, 1'b1, 1'b0, "bounce_a");
        expect_at(n + 12, 8'h0A, 1'b1, 1'b0, "bounce_b");
        expect_at(n + 20, 8'h0A, 1'b1, 1'b0, "bounce_c");
        key_add_n = 1'b0; repeat (3) @(negedge clk);
        key_add_n = 1'b1; repeat (1) @(negedge clk);
        key_add_n = 1'b0; repeat (3) @(negedge clk);
        key_add_n = 1'b1;
        repeat (22) @(negedge clk);

        // positive saturation and recovery
        press(KEY_LOAD, 8'h64, 8'h64, 1'b1, 1'b0, 1'b1, "load_100");
        n = cyc + 1;
        blink_expect(n + 7, 24, 8'h7F, "pos_blink");
        press(KEY_ADD, 8'h32, 8'h7F, 1'b1, 1'b1, 1'b1, "add_sat_pos");
        repeat (12) @(negedge clk);
        n = cyc + 1;
        expect_at(n + 12, 8'h63, 1'b1, 1'b0, "steady_99_a");
        expect_at(n + 16, 8'h63, 1'b1, 1'b0, "steady_99_b");
        press(KEY_ADD, 8'hE4, 8'h63, 1'b1, 1'b0, 1'b0, "add_back_99");

        // negative boundary, then re-entry of overflow
        press(KEY_LOAD, 8'h9C, 8'h9C, 1'b1, 1'b0, 1'b1, "load_m100");
        press(KEY_ADD, 8'hE4, 8'h80, 1'b1, 1'b0, 1'b1, "add_exact_min");
        n = cyc + 1;
        blink_expect(n + 7, 8, 8'h80, "neg_blink");
        press(KEY_ADD, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1, "add_sat_neg");
        n = cyc + 1;
        blink_expect(n + 7, 16, 8'h80, "reenter_blink");
        press(KEY_ADD, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, "add_sat_neg_again");

        // clear and load together: clear wins
        sw = 8'h22;
        n = cyc + 1;
        expect_at(n + 7, 8'h00, 1'b0, 1'b0, "clear_load_same_cycle");
        expect_at(n + 12, 8'h00, 1'b0, 1'b0, "clear_load_stays_blank");
        key_clear_n = 1'b0; key_load_n = 1'b0;
        repeat (6) @(negedge clk);
        key_clear_n = 1'b1; key_load_n = 1'b1;
        repeat (12) @(negedge clk);
        cur_x = 8'h00; cur_en = 1'b0; cur_ovf = 1'b0;
        press(KEY_ADD, 8'h22, 8'h22, 1'b1, 1'b0, 1'b1, "add_from_blank");

        // async reset between edges, key held through reset
        #2 rst_n = 1'b0;
        key_load_n = 1'b0;
        sw = 8'h11;
        #1 check("async_reset", {x, enable, ovf}, 10'h000);
        @(negedge clk);
        rst_n = 1'b1;
        n = cyc + 1;
        expect_at(n + 6, 8'h00, 1'b0, 1'b0, "held_through_reset_early");
        expect_at(n + 7, 8'h11, 1'b1, 1'b0, "held_through_reset");
        repeat (10) @(negedge clk);
        key_load_n = 1'b1;
        repeat (15) @(negedge clk);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never compared", sb[i].nm, sb[i].at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
